btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner.sv | 185 ++++++++++++++++++
 tb/tb_btn_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Conditions raw push-button / switch pins for user logic. Each channel is
// synchronised into the CLK100MHZ domain and debounced to a stable level.
// It produces one-cycle press and release pulses and, optionally, an
// auto-repeat pulse train while the input is held. All channels are
// independent. No channel has priority over another.

module btn_conditioner #(
  parameter int NUM_IN          = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic [NUM_IN-1:0] btn_in,
  output logic [NUM_IN-1:0] btn_level,
  output logic [NUM_IN-1:0] btn_press,
  output logic [NUM_IN-1:0] btn_release,
  output logic [NUM_IN-1:0] btn_repeat,
  output logic              any_press
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // One repeat timer per channel serves both the initial delay and the period.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(RPT_MAX + 1);
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

  // Auto-repeat FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // ---------------------------------------------------------------------------
  // Synchroniser: SYNC_STAGES flops per channel, shared shift structure.
  // ---------------------------------------------------------------------------
  logic [NUM_IN-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IN-1:0] w_synced;

  // Shift the raw pins through the synchroniser chain.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      // NOTE: the synchroniser chain is cleared on reset even though it is a
      // plain shift structure. A held button must look released right after
      // reset, so it is re-debounced and yields a fresh press.
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value. With blocking assignments the chain would collapse
      // into a single flop.
      r_sync[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_synced  = r_sync[SYNC_STAGES-1];
  assign any_press = |btn_press;

  // ---------------------------------------------------------------------------
  // Per-channel debounce, edge pulses and auto-repeat.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_IN; g++) begin : g_chan
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            w_differ;
    logic            w_toggle;
    logic            w_rise;
    logic            w_fall;

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing
    // samples. w_rise / w_fall mark the edge on which that flip happens.
    assign w_differ = w_synced[g] ^ r_level;
    assign w_toggle = w_differ && (r_db_cnt == DB_LAST);
    assign w_rise   = w_toggle && !r_level;
    assign w_fall   = w_toggle &&  r_level;

    // Debounce counter, stable level and registered press/release pulses.
    always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
        r_db_cnt  <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_rise;
        r_release <= w_fall;
        if (w_toggle) begin
          r_level  <= ~r_level;
          r_db_cnt <= '0;
        end else if (w_differ) begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end else begin
          r_db_cnt <= '0;
        end
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;

    if (REPEAT_EN != 0) begin : g_rpt
      logic [1:0]       r_state;
      logic [TMR_W-1:0] r_tmr;
      logic             r_rpt;
      logic [1:0]       w_state_nxt;
      logic [TMR_W-1:0] w_tmr_nxt;
      logic             w_rpt_nxt;

      // Next-state logic. A release always wins over a due repeat pulse.
      always_comb begin
        // NOTE: every output of this block gets a default first. Otherwise a
        // path that leaves one unassigned would infer a latch.
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_rpt_nxt   = 1'b0;
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise) begin
                w_state_nxt = ST_DELAY;
                w_tmr_nxt   = '0;
              end
            end
            ST_DELAY: begin
              if (r_tmr == DLY_LAST) begin
                w_rpt_nxt   = 1'b1;
                w_tmr_nxt   = '0;
                w_state_nxt = ST_REPEAT;
              end else if (r_level) begin
                w_tmr_nxt = r_tmr + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (r_tmr == PER_LAST) begin
                w_rpt_nxt = 1'b1;
                w_tmr_nxt = '0;
              end else begin
                w_tmr_nxt = r_tmr + 1'b1;
              end
            end
            default: begin
              w_state_nxt = ST_IDLE;
              w_tmr_nxt   = '0;
            end
          endcase
        end
      end

      // Register FSM state, timer and the repeat pulse.
      always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
          r_state <= ST_IDLE;
          r_tmr   <= '0;
          r_rpt   <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_tmr   <= w_tmr_nxt;
          r_rpt   <= w_rpt_nxt;
        end
      end

      assign btn_repeat[g] = r_rpt;
    end else begin : g_no_rpt
      assign btn_repeat[g] = 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
// Directed and random stimulus with a scoreboard. The driver runs a
// sliding-window reference model that predicts each edge's outputs and
// queues the non-idle ones. A negedge monitor pops and compares them
// whenever the DUT shows activity or an event is due.

module tb_btn_conditioner;

  localparam int NUM_IN = 5;
  localparam int SS     = 2;
  localparam int DC     = 4;
  localparam int RD     = 10;
  localparam int RP     = 3;
  localparam int MAXE   = 8192;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_IN-1:0] btn_in;
  logic [NUM_IN-1:0] btn_level;
  logic [NUM_IN-1:0] btn_press;
  logic [NUM_IN-1:0] btn_release;
  logic [NUM_IN-1:0] btn_repeat;
  logic              any_press;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_IN(NUM_IN), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK100MHZ  (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .any_press  (any_press)
  );

  typedef struct {
    int                edge_n;
    logic [NUM_IN-1:0] level;
    logic [NUM_IN-1:0] press;
    logic [NUM_IN-1:0] rel;
    logic [NUM_IN-1:0] rpt;
  } ev_t;

  ev_t sb[$];
  int  n_total  = 0;
  int  n_bad    = 0;
  int  edge_cnt = 0;

  // Reference model state: per-edge sampled input history.
  bit                hist [NUM_IN][MAXE];
  bit                rst_at [MAXE];
  int                last_rst = 0;
  logic [NUM_IN-1:0] m_level  = '0;
  int                press_edge [NUM_IN];

  logic [NUM_IN-1:0] mon_prev  = '0;
  logic [NUM_IN-1:0] exp_level = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", name, edge_cnt, got, exp);
    end
  endtask

  // Predict the outputs after edge n, given the inputs sampled at that edge.
  task automatic model_edge(input int n, input logic [NUM_IN-1:0] b, input logic r);
    ev_t               e;
    logic [NUM_IN-1:0] nl;
    bit                all_opp;
    int                d;
    e.edge_n = n;
    e.press  = '0;
    e.rel    = '0;
    e.rpt    = '0;
    rst_at[n] = r;
    if (r) begin
      // Synchroniser contents are zero after reset, so they look like 0 samples.
      for (int c = 0; c < NUM_IN; c++) begin
        for (int k = n - SS + 1; k <= n; k++) begin
          if (k >= 0) hist[c][k] = 1'b0;
        end
        press_edge[c] = -1;
      end
      last_rst = n;
      nl = '0;
    end else begin
      nl = m_level;
      for (int c = 0; c < NUM_IN; c++) begin
        hist[c][n] = b[c];
        // Toggle when the DC samples that reached the debouncer all oppose the level.
        if (n - DC + 1 > last_rst) begin
          all_opp = 1'b1;
          for (int k = n - SS - DC + 1; k <= n - SS; k++) begin
            if (hist[c][k] == m_level[c]) all_opp = 1'b0;
          end
          if (all_opp) begin
            nl[c] = ~m_level[c];
            if (nl[c]) begin
              e.press[c]    = 1'b1;
              press_edge[c] = n;
            end else begin
              e.rel[c]      = 1'b1;
              press_edge[c] = -1;
            end
          end
        end
        if (nl[c] && !e.press[c] && press_edge[c] >= 0) begin
          d = n - press_edge[c];
          if (d >= RD && ((d - RD) % RP) == 0) e.rpt[c] = 1'b1;
        end
      end
    end
    e.level = nl;
    if (nl != m_level || e.press != 0 || e.rel != 0 || e.rpt != 0) sb.push_back(e);
    m_level = nl;
  endtask

  task automatic drive_cycle(input logic [NUM_IN-1:0] b, input logic r);
    btn_in = b;
    rst    = r;
    model_edge(edge_cnt + 1, b, r);
    @(negedge clk);
  endtask

  task automatic hold(input logic [NUM_IN-1:0] b, input int cycles);
    repeat (cycles) drive_cycle(b, 1'b0);
  endtask

  task automatic mon_cycle();
    ev_t e;
    bit  have;
    bit  act;
    if (rst_at[edge_cnt]) begin
      check("reset_clear", {btn_level, btn_press, btn_release, btn_repeat, any_press}, 32'd0);
    end
    have = (sb.size() > 0) && (sb[0].edge_n == edge_cnt);
    if (have) begin
      e = sb.pop_front();
    end else begin
      e.edge_n = edge_cnt;
      e.level  = exp_level;
      e.press  = '0;
      e.rel    = '0;
      e.rpt    = '0;
    end
    act = (|btn_press) || (|btn_release) || (|btn_repeat) || any_press ||
          (btn_level !== mon_prev);
    if (act || have) begin
      check("level",     btn_level,   e.level);
      check("press",     btn_press,   e.press);
      check("release",   btn_release, e.rel);
      check("repeat",    btn_repeat,  e.rpt);
      check("any_press", any_press,   |e.press);
    end
    exp_level = e.level;
    mon_prev  = btn_level;
  endtask

  always @(negedge clk) begin
    if (edge_cnt >= 1) mon_cycle();
  end

  logic [NUM_IN-1:0] cur;
  int                rem [NUM_IN];

  initial begin
    for (int c = 0; c < NUM_IN; c++) begin
      press_edge[c] = -1;
      rem[c]        = 0;
    end
    cur = '0;
    // Power-up reset.
    repeat (3) drive_cycle('0, 1'b1);
    hold('0, 4);
    // Clean press and release on channel 0.
    hold(5'b00001, 20);
    hold('0, 12);
    // Bouncing channel 1, then a steady hold.
    repeat (3) begin
      hold(5'b00010, 2);
      hold('0, 2);
    end
    hold(5'b00010, 20);
    hold('0, 12);
    // Long hold with repeats on channel 2.
    hold(5'b00100, 50);
    hold('0, 12);
    // Release before the first repeat is due.
    hold(5'b00100, 8);
    hold('0, 12);
    // Release lands exactly on a due repeat edge.
    hold(5'b00100, 13);
    hold('0, 12);
    // Simultaneous press on channels 0 and 3.
    hold(5'b01001, 15);
    hold('0, 12);
    // Reset while channel 4 is repeating, then it is re-debounced.
    hold(5'b10000, 25);
    drive_cycle(5'b10000, 1'b1);
    hold(5'b10000, 30);
    hold('0, 12);
    // Random bouncing / holding on all channels with rare resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_IN; c++) begin
        if (rem[c] == 0) begin
          cur[c] = ~cur[c];
          rem[c] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3))
                                              : int'($urandom_range(5, 45));
        end
        rem[c]--;
      end
      drive_cycle(cur, $urandom_range(0, 499) == 0);
    end
    hold('0, 20);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
